idac_sar_cal: RTL
=================

IDAC_SAR_CAL -- requirements
Module: idac_sar_cal

Interface
- REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16, giving the DAC settling cycles per trial bit (1.6 us at the 10 MHz clk); legal range 4..255.
- REQ-002 The block SHALL have port clk, input, 1, the single system clock (10 MHz expected).
- REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
- REQ-004 The block SHALL have port start, input, 1, the calibration request, sampled on clk.
- REQ-005 The block SHALL have port abort, input, 1, which terminates a calibration in progress.
- REQ-006 The block SHALL have port cmp, input, 1, the asynchronous comparator result; 1 means the DAC current exceeds the target.
- REQ-007 The block SHALL have port ib, output, 8, the coarse IDAC code (registered).
- REQ-008 The block SHALL have port ibf, output, 8, the fine IDAC code (registered).
- REQ-009 The block SHALL have port busy, output, 1, high while a calibration runs.
- REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse on successful completion.

Function
- REQ-011 cmp SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
- REQ-012 The FSM SHALL have states IDLE, INIT, SETTLE, DECIDE and DONE, plus a phase flag (COARSE/FINE) and a 3-bit bit index k.
- REQ-013 IDLE: start=1 and abort=0 at edge E0 -> INIT; otherwise stay in IDLE with ib and ibf held.
- REQ-014 INIT (1 cycle) SHALL set ib=8'h80, ibf=8'h00, phase=COARSE, k=7, load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- REQ-015 SETTLE SHALL decrement the counter each cycle and go to DECIDE when the counter is 0.
- REQ-016 DECIDE (1 cycle) SHALL clear bit k of the active code if synchronized cmp=1, else keep it.
- REQ-017 In the same DECIDE cycle, if k>0 the block SHALL set bit k-1 as the next trial, decrement k, reload the counter and go to SETTLE.
- REQ-018 At COARSE, k=0 DECIDE SHALL switch phase to FINE, set ibf=8'h80 and k=7, and go to SETTLE.
- REQ-019 At FINE, k=0 DECIDE SHALL go to DONE.
- REQ-020 DONE SHALL last 1 cycle with done=1, then go to IDLE; ib and ibf hold the final codes until the next start or reset.
- REQ-021 Each bit SHALL take exactly SETTLE_CYCLES+1 cycles; done SHALL be high in the cycle after edge E0+1+16*(SETTLE_CYCLES+1), i.e. edge 273 for the default.
- REQ-022 busy SHALL be 1 in INIT, SETTLE and DECIDE, and 0 in IDLE and DONE.
- REQ-023 start while busy=1 SHALL be ignored, with no queuing.
- REQ-024 abort=1 in any non-IDLE state SHALL move to IDLE at the next edge, hold ib/ibf at their current values, give busy=0 after that edge, and assert no done.
- REQ-025 When start and abort are both 1 in IDLE, abort wins and no calibration starts.
- REQ-026 The codes SHALL never wrap: the SAR yields the largest code with cmp=0 and saturates at 8'h00 or 8'hFF.

Reset
- REQ-027 reset=1 at a clk edge SHALL give state=IDLE, ib=8'h7F, ibf=8'h00, busy=0, done=0, and clear the synchronizer, counter, phase and k.
- REQ-028 reset SHALL override start and abort, and reset mid-calibration SHALL behave identically to reset from IDLE.

Structure
- REQ-029 Shared package idac_cal_pkg SHALL hold the FSM state enum, CODE_W=8, IB_RST=8'h7F and IBF_RST=8'h00.
- REQ-030 The synchronizer SHALL be a separate sub-module sync2 (1-bit, 2-flop, synchronous active-high reset); everything else lives in idac_sar_cal.

Verification
- REQ-031 Reset test: assert reset 3 cycles -> ib=7F, ibf=00, busy=0, done=0.
- REQ-032 Converge test: cmp model = ({ib,ibf} > 16'h5A3C), one start pulse -> done at edge 273, then ib=5A, ibf=3C, busy=0.
- REQ-033 Saturation test: cmp tied to 1 -> ib=00, ibf=00; cmp tied to 0 -> ib=FF, ibf=FF; done pulses exactly once in each case.
- REQ-034 Abort test: abort during coarse k=4 -> busy=0 next cycle, no done, codes held; a following start completes normally.
- REQ-035 Ignore test: start pulses every 20 cycles while busy -> exactly one done, timing unchanged; start and abort together in IDLE -> busy stays 0.
- REQ-036 Reset mid-run test: reset during FINE phase -> ib=7F, ibf=00, state IDLE, no done.

Source files
------------

// File: rtl/idac_cal_pkg.sv
// Shared definitions for the IDAC SAR calibration controller.
package idac_cal_pkg;

  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] IB_RST  = 8'h7F;
  localparam logic [CODE_W-1:0] IBF_RST = 8'h00;
  localparam logic [CODE_W-1:0] CODE_MID = 8'h80;

  localparam logic PH_COARSE = 1'b0;
  localparam logic PH_FINE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/idac_sar_cal.sv
// Two-phase (coarse then fine) SAR calibration of the IDAC codes against
// a comparator; each trial bit waits SETTLE_CYCLES before it is decided.
//
// state  | meaning
// IDLE   | waiting for start, codes held
// INIT   | load first coarse trial (ib=80, ibf=00)
// SETTLE | DAC settling, counter running down
// DECIDE | keep/clear bit k, set next trial bit or change phase
// DONE   | one-cycle done pulse
module idac_sar_cal
  import idac_cal_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp,
  output logic [CODE_W-1:0] ib,
  output logic [CODE_W-1:0] ibf,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic              phase;
  logic [2:0]        k;
  logic              cmp_s;
  logic [CODE_W-1:0] trial;

  sync2 u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (cmp),
    .q    (cmp_s)
  );

  // Decided code for bit k, with the next trial bit already set when k > 0.
  always_comb begin
    trial = (phase == PH_FINE) ? ibf : ib;
    if (cmp_s) trial[k] = 1'b0;
    if (k != 3'd0) trial[k - 3'd1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ib    <= IB_RST;
      ibf   <= IBF_RST;
      cnt   <= 8'd0;
      phase <= PH_COARSE;
      k     <= 3'd0;
    end else if (state != ST_IDLE && abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) state <= ST_INIT;
        end
        ST_INIT: begin
          ib    <= CODE_MID;
          ibf   <= 8'h00;
          phase <= PH_COARSE;
          k     <= 3'd7;
          cnt   <= CNT_LOAD;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == 8'd0) state <= ST_DECIDE;
          else             cnt   <= cnt - 8'd1;
        end
        ST_DECIDE: begin
          if (phase == PH_FINE) ibf <= trial;
          else                  ib  <= trial;
          if (k != 3'd0) begin
            k     <= k - 3'd1;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end else if (phase == PH_COARSE) begin
            phase <= PH_FINE;
            ibf   <= CODE_MID;
            k     <= 3'd7;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_INIT) || (state == ST_SETTLE) || (state == ST_DECIDE);
  assign done = (state == ST_DONE);

endmodule
